// File: rtl/axi_conf_pkg.sv
// AXI4 channel and bundle types used on both sides of the IO-PMP.
// Latency: n/a (types only).
// Backpressure: n/a.
package axi_conf;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned UserWidth = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [UserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [UserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
        logic [UserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

endpackage

// File: rtl/axi_io_pmp_pkg.sv
// Shared IO-PMP definitions: write FSM states, rv64 widths, SLVERR B beat.
// Latency: n/a (types only).
// Backpressure: n/a.
package axi_io_pmp_pkg;

    localparam int unsigned PLEN_RV64    = 56;
    localparam int unsigned PMP_LEN_RV64 = 54;

    typedef enum logic [2:0] {
        IDLE,
        FWD_W,
        FWD_B,
        DRAIN_W,
        ERR_B
    } wr_state_e;

    // Locally generated error response; id is filled in from the latched AW.
    localparam axi_conf::b_chan_t B_SLVERR = '{
        id:   '0,
        resp: axi_conf::RESP_SLVERR,
        user: '0
    };

endpackage

// File: rtl/riscv_pkg.sv
// RISC-V privilege and PMP configuration types shared by the PMP checker.
// Latency: n/a (types only).
// Backpressure: n/a.
package riscv;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

    typedef enum logic [2:0] {
        ACCESS_NONE  = 3'b000,
        ACCESS_READ  = 3'b001,
        ACCESS_WRITE = 3'b010,
        ACCESS_EXEC  = 3'b100
    } pmp_access_t;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        TOR   = 2'b01,
        NA4   = 2'b10,
        NAPOT = 2'b11
    } pmp_addr_mode_t;

    // Bit order matches pmp_access_t so the two can be ANDed directly.
    typedef struct packed {
        logic x;
        logic w;
        logic r;
    } pmpcfg_access_t;

    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_t addr_mode;
        pmpcfg_access_t access_type;
    } pmpcfg_t;

endpackage

// File: rtl/axi_io_pmp_wr_if.sv
// AXI request/response bundle for one side of the IO-PMP.
// Latency: n/a (wires only).
// Backpressure: carried by the valid/ready fields inside the bundle.
interface axi_io_pmp_wr_if;
    axi_conf::req_t  req;
    axi_conf::resp_t resp;

    modport master (output req, input  resp);
    modport slave  (input  req, output resp);
endinterface

// File: rtl/axi_io_pmp_err_slv.sv
// Error responder: swallows the W beats of a rejected burst, then returns SLVERR.
// Latency: SLVERR B valid the cycle after the final absorbed W beat.
// Backpressure: W always accepted while draining; B held until b_ready_i.
module axi_io_pmp_err_slv
    import axi_io_pmp_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [axi_conf::IdWidth-1:0]  id_i,
    input  logic [7:0]                    len_i,
    input  logic                          w_valid_i,
    input  logic                          w_last_i,
    output logic                          w_ready_o,
    output logic                          b_valid_o,
    output axi_conf::b_chan_t             b_o,
    input  logic                          b_ready_i,
    output logic                          drain_done_o,
    output logic                          resp_done_o
);

    wr_state_e                      state_q;
    logic [7:0]                     cnt_q;
    logic [axi_conf::IdWidth-1:0]   id_q;
    logic                           w_ready_q;
    logic                           b_valid_q;
    logic                           w_hs;

    assign w_hs         = w_valid_i & w_ready_q;
    // Whichever of w.last or the beat count comes first ends the drain.
    assign drain_done_o = w_hs & (w_last_i | (cnt_q == 8'd0));
    assign resp_done_o  = b_valid_q & b_ready_i;
    assign w_ready_o    = w_ready_q;
    assign b_valid_o    = b_valid_q;

    // Response beat is the SLVERR template stamped with the captured id.
    always_comb begin
        b_o    = B_SLVERR;
        b_o.id = id_q;
    end

    // Drain/respond sequencer with registered ready/valid outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            id_q      <= '0;
            w_ready_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        id_q      <= id_i;
                        cnt_q     <= len_i;
                        w_ready_q <= 1'b1;
                        state_q   <= DRAIN_W;
                    end
                end
                DRAIN_W: begin
                    if (w_hs) begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                    if (drain_done_o) begin
                        w_ready_q <= 1'b0;
                        b_valid_q <= 1'b1;
                        state_q   <= ERR_B;
                    end
                end
                ERR_B: begin
                    if (resp_done_o) begin
                        b_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    w_ready_q <= 1'b0;
                    b_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/pmp.sv
// Combinational PMP check: lowest-numbered matching entry decides access.
// Latency: 0 cycles.
// Backpressure: none.
module pmp #(
    parameter int unsigned PLEN       = 56,
    parameter int unsigned PMP_LEN    = 54,
    parameter int unsigned NR_ENTRIES = 16
) (
    input  logic [PLEN-1:0]                      addr_i,
    input  riscv::pmp_access_t                   access_type_i,
    input  riscv::priv_lvl_t                     priv_lvl_i,
    input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]   conf_addr_i,
    input  riscv::pmpcfg_t [NR_ENTRIES-1:0]      conf_i,
    output logic                                 allow_o
);

    localparam logic [PLEN-1:0] One = PLEN'(1);

    logic [PLEN-1:0] lo;
    logic [PLEN-1:0] hi;
    logic [PLEN-1:0] napot_base;
    logic [PLEN-1:0] napot_mask;
    logic            hit;
    logic            found;
    logic            sel_locked;
    logic [2:0]      sel_perm;

    // Walk entries in order; TOR uses the previous entry as its lower bound.
    always_comb begin
        lo         = '0;
        hi         = '0;
        napot_base = '0;
        napot_mask = '0;
        hit        = 1'b0;
        found      = 1'b0;
        sel_locked = 1'b0;
        sel_perm   = 3'b000;
        for (int i = 0; i < int'(NR_ENTRIES); i++) begin
            hi         = {conf_addr_i[i], 2'b00};
            napot_base = {conf_addr_i[i], 2'b11};
            // Trailing-ones run of the base (plus the next bit) is the region mask.
            napot_mask = napot_base ^ (napot_base + One);
            case (conf_i[i].addr_mode)
                riscv::TOR:   hit = (addr_i >= lo) && (addr_i < hi);
                riscv::NA4:   hit = (addr_i[PLEN-1:2] == conf_addr_i[i]);
                riscv::NAPOT: hit = ((addr_i ^ napot_base) & ~napot_mask) == '0;
                default:      hit = 1'b0;
            endcase
            if (hit && !found) begin
                found      = 1'b1;
                sel_locked = conf_i[i].locked;
                sel_perm   = conf_i[i].access_type;
            end
            lo = hi;
        end
        if (found) begin
            allow_o = ((priv_lvl_i == riscv::PRIV_LVL_M) && !sel_locked) ||
                      ((3'(access_type_i) & sel_perm) == 3'(access_type_i));
        end else begin
            allow_o = (priv_lvl_i == riscv::PRIV_LVL_M);
        end
    end

endmodule

// File: rtl/axi_io_pmp_wr.sv
// IO-PMP write checker: forwards permitted AW bursts, answers denied ones with SLVERR.
// Latency: 0 cycles on the permitted path; SLVERR B one cycle after the last drained W.
// Backpressure: one write outstanding; W stalled until AW accepted; AR/R pass through.
// Optional AXI_IO_PMP_WR_FAULT_EN adds fault_irq_o / fault_addr_o / fault_clr_i.
module axi_io_pmp_wr
    import axi_io_pmp_pkg::*;
#(
    parameter int unsigned PLEN       = PLEN_RV64,
    parameter int unsigned PMP_LEN    = PMP_LEN_RV64,
    parameter int unsigned NR_ENTRIES = 16,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    axi_io_pmp_wr_if.slave                      slv,
    axi_io_pmp_wr_if.master                     mst,
    input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]  cfg_addr_i,
    input  riscv::pmpcfg_t [NR_ENTRIES-1:0]     cfg_i,
    output logic [CNT_WIDTH-1:0]                deny_cnt_o
`ifdef AXI_IO_PMP_WR_FAULT_EN
    ,
    input  logic                                fault_clr_i,
    output logic                                fault_irq_o,
    output logic [PLEN-1:0]                     fault_addr_o
`endif
);

    wr_state_e              state_q;
    logic [7:0]             cnt_q;
    logic [CNT_WIDTH-1:0]   deny_cnt_q;

    axi_conf::req_t         mst_req;
    axi_conf::resp_t        slv_resp;
    logic                   allow;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   b_hs;
    logic                   deny_start;

    logic                   err_w_ready;
    logic                   err_b_valid;
    axi_conf::b_chan_t      err_b;
    logic                   err_drain_done;
    logic                   err_resp_done;

    pmp #(
        .PLEN       (PLEN),
        .PMP_LEN    (PMP_LEN),
        .NR_ENTRIES (NR_ENTRIES)
    ) i_pmp (
        .addr_i        (slv.req.aw.addr[PLEN-1:0]),
        .access_type_i (riscv::ACCESS_WRITE),
        .priv_lvl_i    (riscv::PRIV_LVL_S),
        .conf_addr_i   (cfg_addr_i),
        .conf_i        (cfg_i),
        .allow_o       (allow)
    );

    axi_io_pmp_err_slv i_err_slv (
        .clk          (clk),
        .rst          (rst),
        .start_i      (deny_start),
        .id_i         (slv.req.aw.id),
        .len_i        (slv.req.aw.len),
        .w_valid_i    (slv.req.w_valid),
        .w_last_i     (slv.req.w.last),
        .w_ready_o    (err_w_ready),
        .b_valid_o    (err_b_valid),
        .b_o          (err_b),
        .b_ready_i    (slv.req.b_ready),
        .drain_done_o (err_drain_done),
        .resp_done_o  (err_resp_done)
    );

    // Everything passes through by default; only the write handshakes are gated per state.
    always_comb begin
        mst_req          = slv.req;
        slv_resp         = mst.resp;
        mst_req.aw_valid = 1'b0;
        mst_req.w_valid  = 1'b0;
        mst_req.b_ready  = 1'b0;
        slv_resp.aw_ready = 1'b0;
        slv_resp.w_ready  = 1'b0;
        slv_resp.b_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                mst_req.aw_valid  = slv.req.aw_valid & allow;
                // A denied AW is taken locally so the device is never stuck on it.
                slv_resp.aw_ready = allow ? mst.resp.aw_ready : 1'b1;
            end
            FWD_W: begin
                mst_req.w_valid  = slv.req.w_valid;
                slv_resp.w_ready = mst.resp.w_ready;
            end
            FWD_B: begin
                slv_resp.b_valid = mst.resp.b_valid;
                mst_req.b_ready  = slv.req.b_ready;
            end
            DRAIN_W: begin
                slv_resp.w_ready = err_w_ready;
            end
            ERR_B: begin
                slv_resp.b_valid = err_b_valid;
                slv_resp.b       = err_b;
            end
            default: begin
                slv_resp.b_valid = 1'b0;
            end
        endcase
    end

    assign mst.req  = mst_req;
    assign slv.resp = slv_resp;

    assign aw_hs      = slv.req.aw_valid & slv_resp.aw_ready;
    assign w_hs       = slv.req.w_valid & slv_resp.w_ready;
    assign b_hs       = mst.resp.b_valid & mst_req.b_ready;
    assign deny_start = (state_q == IDLE) & aw_hs & ~allow;
    assign deny_cnt_o = deny_cnt_q;

    // Main write FSM plus the saturating denied-burst counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            deny_cnt_q <= '0;
        end else begin
            if (deny_start && (deny_cnt_q != '1)) begin
                deny_cnt_q <= deny_cnt_q + CNT_WIDTH'(1);
            end
            case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        cnt_q   <= slv.req.aw.len;
                        state_q <= allow ? FWD_W : DRAIN_W;
                    end
                end
                FWD_W: begin
                    if (w_hs) begin
                        cnt_q <= cnt_q - 8'd1;
                        if (slv.req.w.last || (cnt_q == 8'd0)) begin
                            state_q <= FWD_B;
                        end
                    end
                end
                FWD_B: begin
                    if (b_hs) begin
                        state_q <= IDLE;
                    end
                end
                DRAIN_W: begin
                    if (err_drain_done) begin
                        state_q <= ERR_B;
                    end
                end
                ERR_B: begin
                    if (err_resp_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AXI_IO_PMP_WR_FAULT_EN
    logic            fault_irq_q;
    logic            fault_held_q;
    logic [PLEN-1:0] fault_addr_q;

    // First denied address is sticky until software clears it; clearing also zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_irq_q  <= 1'b0;
            fault_held_q <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            fault_irq_q <= deny_start;
            if (fault_clr_i) begin
                fault_held_q <= 1'b0;
                fault_addr_q <= '0;
            end
            if (deny_start && (!fault_held_q || fault_clr_i)) begin
                fault_held_q <= 1'b1;
                fault_addr_q <= slv.req.aw.addr[PLEN-1:0];
            end
        end
    end

    assign fault_irq_o  = fault_irq_q;
    assign fault_addr_o = fault_addr_q;
`endif

endmodule
